// File: rtl/sclk_period_monitor_pkg.sv
// Shared definitions for the slow-clock period monitor: FSM encoding and the
// nominal half-period/tolerance values also used by the clock divider.
package sclk_period_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2,
        ST_LOCK = 2'd3
    } mon_state_e;

    localparam int DEF_CW       = 16;
    localparam int DEF_EXP_HALF = 751;
    localparam int DEF_TOL      = 8;
    localparam int DEF_LOCK_CNT = 4;
    localparam int DEF_TIMEOUT  = 2048;

    // Inclusive window test on a signed deviation from the nominal half period.
    function automatic logic within_tol(input int diff, input int tol);
        return (diff <= tol) && (diff >= -tol);
    endfunction

endpackage

// File: rtl/sclk_period_monitor_sync_edge_det.sv
// Two-flop resynchroniser for the slow clock with an edge indicator and
// registered, maskable rise/fall strobes.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    input  logic pass_i,
    output logic edge_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= async_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            rise_q <= pass_i & s2_q & ~prev_q;
            fall_q <= pass_i & ~s2_q & prev_q;
        end
    end

    assign edge_o = s2_q ^ prev_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/sclk_period_monitor.sv
// Measures each half period of a resynchronised slow clock, declares lock
// after a run of in-tolerance measurements and flags range/timeout errors.
module sclk_period_monitor
    import sclk_period_monitor_pkg::*;
#(
    parameter int CW       = DEF_CW,
    parameter int EXP_HALF = DEF_EXP_HALF,
    parameter int TOL      = DEF_TOL,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          sclk_in_i,
    output logic          rise_o,
    output logic          fall_o,
    output logic [CW-1:0] half_period_o,
    output logic          meas_valid_o,
    output logic          locked_o,
    output logic          err_range_o,
    output logic          err_timeout_o
);

    localparam int            RW     = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] EXP_W  = CW'(EXP_HALF);
    localparam logic [CW-1:0] TO_W   = CW'(TIMEOUT);
    localparam logic [RW-1:0] LOCK_W = RW'(LOCK_CNT);

    mon_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] half_q, half_d;
    logic [RW-1:0] run_q, run_d;
    logic          meas_q, meas_d;
    logic          locked_q, locked_d;
    logic          errRange_q, errRange_d;
    logic          errTimeout_q, errTimeout_d;

    logic          edgeSeen;
    logic          strobePass;
    logic          inRange;
    logic          lockReached;
    logic          timeoutHit;
    logic [RW-1:0] runInc;
    logic signed [CW:0] diff;

    assign strobePass = en_i && (state_q != ST_IDLE);

    sync_edge_det u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (sclk_in_i),
        .pass_i  (strobePass),
        .edge_o  (edgeSeen),
        .rise_o  (rise_o),
        .fall_o  (fall_o)
    );

    // The value measured is the count reached in the cycle the edge is seen.
    assign diff        = $signed({1'b0, cnt_q}) - $signed({1'b0, EXP_W});
    assign inRange     = within_tol(int'(diff), TOL);
    assign runInc      = run_q + RW'(1);
    assign lockReached = (runInc == LOCK_W);
    assign timeoutHit  = (cnt_q == TO_W) && !edgeSeen;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM:  if (edgeSeen) state_d = ST_MEAS;
                ST_MEAS: begin
                    if (edgeSeen) begin
                        if (inRange && lockReached) state_d = ST_LOCK;
                    end else if (timeoutHit) begin
                        state_d = ST_ARM;
                    end
                end
                ST_LOCK: begin
                    if (edgeSeen) begin
                        if (!inRange) state_d = ST_MEAS;
                    end else if (timeoutHit) begin
                        state_d = ST_ARM;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // An edge always restarts the count, which makes an edge coinciding with
    // the timeout count a normal measurement rather than a timeout.
    always_comb begin
        cnt_d        = edgeSeen ? CW'(1) : ((cnt_q == '1) ? cnt_q : cnt_q + CW'(1));
        half_d       = half_q;
        run_d        = run_q;
        meas_d       = 1'b0;
        locked_d     = locked_q;
        errRange_d   = 1'b0;
        errTimeout_d = 1'b0;
        if (!en_i || state_q == ST_IDLE) begin
            cnt_d    = '0;
            run_d    = '0;
            locked_d = 1'b0;
        end else if (state_q == ST_MEAS || state_q == ST_LOCK) begin
            if (edgeSeen) begin
                meas_d = 1'b1;
                half_d = cnt_q;
                if (!inRange) begin
                    run_d      = '0;
                    locked_d   = 1'b0;
                    errRange_d = (state_q == ST_LOCK);
                end else if (state_q == ST_MEAS) begin
                    run_d = runInc;
                    if (lockReached) locked_d = 1'b1;
                end
            end else if (timeoutHit) begin
                errTimeout_d = 1'b1;
                run_d        = '0;
                locked_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            half_q       <= '0;
            run_q        <= '0;
            meas_q       <= 1'b0;
            locked_q     <= 1'b0;
            errRange_q   <= 1'b0;
            errTimeout_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            half_q       <= half_d;
            run_q        <= run_d;
            meas_q       <= meas_d;
            locked_q     <= locked_d;
            errRange_q   <= errRange_d;
            errTimeout_q <= errTimeout_d;
        end
    end

    assign half_period_o = half_q;
    assign meas_valid_o  = meas_q;
    assign locked_o      = locked_q;
    assign err_range_o   = errRange_q;
    assign err_timeout_o = errTimeout_q;

endmodule
